// File: rtl/afe_buf_wr_arbiter.sv
// -----------------------------------------------------------------------------
// afe_buf_wr_arbiter
//
// Shares the single write port of the AFE sample buffer between NUM_ADCS ADC
// readout tops. Each ADC's sample pulse lands in a one-deep holding slot. A
// round-robin FSM (IDLE -> GRANT -> WRITE) grants one ADC at a time, waits for
// that ADC's write-grant acknowledge and then issues exactly one buffer write
// using the address the ADC presented in the ack cycle.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   arb_en_i            0 = no new grants (a running transaction completes)
//   buf_busy_i          read side owns the buffer; blocks new grants only
//   adc_valid_i[n]      sample-valid pulse of ADC n
//   adc_data_i          packed samples, ADC0 in the LSBs
//   adc_buf_addr_i      packed current buffer address per ADC
//   wr_grant_ack_i[n]   write-grant acknowledge of ADC n
//   err_clr_i           clears the sticky ovf_o / tmo_o flags
//   adc_grant_o         one-hot (or zero) grant to the ADC tops
//   buf_wr_en_o         one-cycle buffer write strobe
//   buf_wr_addr_o/data  write address/data, held while buf_wr_en_o is low
//   pending_o[n]        holding slot n occupied
//   ovf_o[n]            sticky: a sample of ADC n was dropped
//   tmo_o[n]            sticky: ADC n did not ack within ACK_TIMEOUT cycles
// -----------------------------------------------------------------------------
module afe_buf_wr_arbiter #(
    parameter int NUM_ADCS    = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int BUF_AWIDTH  = 10,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           arb_en_i,
    input  logic                           buf_busy_i,
    input  logic [NUM_ADCS-1:0]            adc_valid_i,
    input  logic [NUM_ADCS*DATA_WIDTH-1:0] adc_data_i,
    input  logic [NUM_ADCS*BUF_AWIDTH-1:0] adc_buf_addr_i,
    input  logic [NUM_ADCS-1:0]            wr_grant_ack_i,
    input  logic                           err_clr_i,
    output logic [NUM_ADCS-1:0]            adc_grant_o,
    output logic                           buf_wr_en_o,
    output logic [BUF_AWIDTH-1:0]          buf_wr_addr_o,
    output logic [DATA_WIDTH-1:0]          buf_wr_data_o,
    output logic [NUM_ADCS-1:0]            pending_o,
    output logic [NUM_ADCS-1:0]            ovf_o,
    output logic [NUM_ADCS-1:0]            tmo_o
);

    localparam int                IDX_W        = $clog2(NUM_ADCS);
    localparam logic [IDX_W:0]    NUM_ADCS_EXT = (IDX_W+1)'(NUM_ADCS);
    localparam logic [IDX_W-1:0]  LAST_IDX     = IDX_W'(NUM_ADCS - 1);
    localparam logic [7:0]        TMO_LAST     = 8'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_WRITE
    } state_t;

    // Unpacked views of the packed per-ADC buses.
    logic [NUM_ADCS-1:0][DATA_WIDTH-1:0] adc_data_a;
    logic [NUM_ADCS-1:0][BUF_AWIDTH-1:0] adc_addr_a;
    assign adc_data_a = adc_data_i;
    assign adc_addr_a = adc_buf_addr_i;

    state_t                              state_q, state_d;
    logic [IDX_W-1:0]                    rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]                    winner_q, winner_d;
    logic [NUM_ADCS-1:0]                 grant_q, grant_d;
    logic [7:0]                          tmo_cnt_q, tmo_cnt_d;
    logic                                wr_en_q, wr_en_d;
    logic [BUF_AWIDTH-1:0]               wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0]               wr_data_q, wr_data_d;
    logic [NUM_ADCS-1:0]                 pending_q, pending_d;
    logic [NUM_ADCS-1:0]                 ovf_q, ovf_d;
    logic [NUM_ADCS-1:0]                 tmo_q, tmo_d;
    logic [NUM_ADCS-1:0][DATA_WIDTH-1:0] slot_data_q, slot_data_d;

    logic                                search_hit;
    logic [IDX_W-1:0]                    search_idx;
    logic                                start_grant;
    logic                                ack_accept;
    logic                                timeout_hit;
    logic [IDX_W-1:0]                    next_ptr;
    logic [NUM_ADCS-1:0]                 release_vec;
    logic [NUM_ADCS-1:0]                 ovf_set;
    logic [NUM_ADCS-1:0]                 tmo_set;

    // -------------------------------------------------------------------------
    // Round-robin search: first pending slot at or above rr_ptr, wrapping.
    // Scanning from the far end lets the closest candidate overwrite the rest.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        logic [IDX_W:0] cand;
        search_hit = 1'b0;
        search_idx = '0;
        cand       = '0;
        for (int i = NUM_ADCS - 1; i >= 0; i--) begin
            cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
            if (cand >= NUM_ADCS_EXT) begin
                cand = cand - NUM_ADCS_EXT;
            end
            if (pending_q[cand[IDX_W-1:0]]) begin
                search_hit = 1'b1;
                search_idx = cand[IDX_W-1:0];
            end
        end
    end

    assign start_grant = (state_q == ST_IDLE) && arb_en_i && !buf_busy_i && search_hit;
    assign ack_accept  = (state_q == ST_GRANT) && wr_grant_ack_i[winner_q];
    assign timeout_hit = (state_q == ST_GRANT) && !wr_grant_ack_i[winner_q]
                         && (tmo_cnt_q == TMO_LAST);
    assign next_ptr    = (winner_q == LAST_IDX) ? '0 : winner_q + IDX_W'(1);

    always_comb begin
        release_vec = '0;
        if (ack_accept) begin
            release_vec[winner_q] = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start_grant) state_d = ST_GRANT;
            ST_GRANT: begin
                if (ack_accept) begin
                    state_d = ST_WRITE;
                end else if (timeout_hit) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM outputs: grant, pointer, timeout counter and write port registers.
    // -------------------------------------------------------------------------
    always_comb begin
        grant_d   = grant_q;
        winner_d  = winner_q;
        rr_ptr_d  = rr_ptr_q;
        tmo_cnt_d = tmo_cnt_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        tmo_set   = '0;
        unique case (state_q)
            ST_IDLE: begin
                tmo_cnt_d = '0;
                grant_d   = '0;
                if (start_grant) begin
                    winner_d            = search_idx;
                    grant_d[search_idx] = 1'b1;
                end
            end
            ST_GRANT: begin
                if (ack_accept) begin
                    // Address is the ADC's pre-increment value seen in the ack cycle.
                    wr_addr_d = adc_addr_a[winner_q];
                    wr_data_d = slot_data_q[winner_q];
                    wr_en_d   = 1'b1;
                    grant_d   = '0;
                    rr_ptr_d  = next_ptr;
                end else if (timeout_hit) begin
                    tmo_set[winner_q] = 1'b1;
                    grant_d           = '0;
                    rr_ptr_d          = next_ptr;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
            end
            ST_WRITE: grant_d = '0;
            default:  grant_d = '0;
        endcase
    end

    // -------------------------------------------------------------------------
    // Holding slots. A release in the same cycle as a new pulse frees room for
    // it, so that case is a capture rather than an overflow.
    // -------------------------------------------------------------------------
    always_comb begin
        pending_d   = pending_q;
        slot_data_d = slot_data_q;
        ovf_set     = '0;
        for (int n = 0; n < NUM_ADCS; n++) begin
            if (adc_valid_i[n]) begin
                if (!pending_q[n] || release_vec[n]) begin
                    slot_data_d[n] = adc_data_a[n];
                    pending_d[n]   = 1'b1;
                end else begin
                    ovf_set[n] = 1'b1;
                end
            end else if (release_vec[n]) begin
                pending_d[n] = 1'b0;
            end
        end
    end

    // Clear only wipes flags that are not being set in the same cycle.
    always_comb begin
        ovf_d = (err_clr_i ? '0 : ovf_q) | ovf_set;
        tmo_d = (err_clr_i ? '0 : tmo_q) | tmo_set;
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst_i) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= '0;
            winner_q  <= '0;
            grant_q   <= '0;
            tmo_cnt_q <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            pending_q <= '0;
            ovf_q     <= '0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            winner_q  <= winner_d;
            grant_q   <= grant_d;
            tmo_cnt_q <= tmo_cnt_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
            tmo_q     <= tmo_d;
        end
    end

    // NOTE: slot data is storage, not control; it is never read unless its
    // pending bit is set, so it carries no reset.
    always_ff @(posedge clk_i) begin
        slot_data_q <= slot_data_d;
    end

    assign adc_grant_o   = grant_q;
    assign buf_wr_en_o   = wr_en_q;
    assign buf_wr_addr_o = wr_addr_q;
    assign buf_wr_data_o = wr_data_q;
    assign pending_o     = pending_q;
    assign ovf_o         = ovf_q;
    assign tmo_o         = tmo_q;

endmodule

// File: tb/tb_afe_buf_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_afe_buf_wr_arbiter
//
// Directed scenarios followed by a randomized run. A transaction-level model
// (who holds the buffer port, how long it has held it, what is queued per ADC)
// predicts every output each cycle; the directed scenarios add fixed-value
// checks on the key events.
// -----------------------------------------------------------------------------
module tb_afe_buf_wr_arbiter;

    localparam int N   = 4;
    localparam int DW  = 32;
    localparam int AW  = 10;
    localparam int TMO = 15;

    logic                 clk = 1'b0;
    logic                 rst_i;
    logic                 arb_en_i;
    logic                 buf_busy_i;
    logic [N-1:0]         adc_valid_i;
    logic [N-1:0][DW-1:0] adc_data_i;
    logic [N-1:0][AW-1:0] adc_buf_addr_i;
    logic [N-1:0]         wr_grant_ack_i;
    logic                 err_clr_i;
    logic [N-1:0]         adc_grant_o;
    logic                 buf_wr_en_o;
    logic [AW-1:0]        buf_wr_addr_o;
    logic [DW-1:0]        buf_wr_data_o;
    logic [N-1:0]         pending_o;
    logic [N-1:0]         ovf_o;
    logic [N-1:0]         tmo_o;

    always #5 clk = ~clk;

    afe_buf_wr_arbiter #(
        .NUM_ADCS    (N),
        .DATA_WIDTH  (DW),
        .BUF_AWIDTH  (AW),
        .ACK_TIMEOUT (TMO)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .arb_en_i       (arb_en_i),
        .buf_busy_i     (buf_busy_i),
        .adc_valid_i    (adc_valid_i),
        .adc_data_i     (adc_data_i),
        .adc_buf_addr_i (adc_buf_addr_i),
        .wr_grant_ack_i (wr_grant_ack_i),
        .err_clr_i      (err_clr_i),
        .adc_grant_o    (adc_grant_o),
        .buf_wr_en_o    (buf_wr_en_o),
        .buf_wr_addr_o  (buf_wr_addr_o),
        .buf_wr_data_o  (buf_wr_data_o),
        .pending_o      (pending_o),
        .ovf_o          (ovf_o),
        .tmo_o          (tmo_o)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------ model
    bit            m_queued[N];     // sample waiting in ADC n's slot
    logic [DW-1:0] m_sample[N];     // that sample
    int            m_next_first;    // ADC searched first for the next grant
    int            m_owner;         // ADC currently granted, -1 if none
    int            m_held;          // cycles the owner has held the grant
    bit            m_writing;       // write strobe visible this cycle
    logic [AW-1:0] m_waddr;
    logic [DW-1:0] m_wdata;
    logic [N-1:0]  m_ovf;
    logic [N-1:0]  m_tmo;

    // Advances the model by one clock edge using the inputs present at it.
    task automatic model_step();
        int           freed;
        bit           will_write;
        logic [N-1:0] lost;
        logic [N-1:0] late;
        if (rst_i) begin
            foreach (m_queued[n]) m_queued[n] = 1'b0;
            m_next_first = 0;
            m_owner      = -1;
            m_held       = 0;
            m_writing    = 1'b0;
            m_waddr      = '0;
            m_wdata      = '0;
            m_ovf        = '0;
            m_tmo        = '0;
            return;
        end
        freed      = -1;
        will_write = 1'b0;
        lost       = '0;
        late       = '0;
        if (m_writing) begin
            // the write cycle is followed by an idle cycle: nothing new here
        end else if (m_owner >= 0) begin
            if (wr_grant_ack_i[m_owner]) begin
                freed        = m_owner;
                m_waddr      = adc_buf_addr_i[m_owner];
                m_wdata      = m_sample[m_owner];
                will_write   = 1'b1;
                m_next_first = (m_owner + 1) % N;
                m_owner      = -1;
            end else begin
                m_held++;
                if (m_held == TMO) begin
                    late[m_owner] = 1'b1;
                    m_next_first  = (m_owner + 1) % N;
                    m_owner       = -1;
                end
            end
        end else if (arb_en_i && !buf_busy_i) begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_next_first + k) % N;
                if (m_owner < 0 && m_queued[j]) begin
                    m_owner = j;
                    m_held  = 0;
                end
            end
        end
        for (int n = 0; n < N; n++) begin
            if (adc_valid_i[n]) begin
                if (!m_queued[n] || freed == n) begin
                    m_sample[n] = adc_data_i[n];
                    m_queued[n] = 1'b1;
                end else begin
                    lost[n] = 1'b1;
                end
            end else if (freed == n) begin
                m_queued[n] = 1'b0;
            end
        end
        m_ovf     = (err_clr_i ? '0 : m_ovf) | lost;
        m_tmo     = (err_clr_i ? '0 : m_tmo) | late;
        m_writing = will_write;
    endtask

    task automatic compare_all();
        logic [N-1:0] exp_grant;
        logic [N-1:0] exp_pend;
        exp_grant = '0;
        if (m_owner >= 0) exp_grant[m_owner] = 1'b1;
        for (int n = 0; n < N; n++) exp_pend[n] = m_queued[n];
        check("grant",   adc_grant_o,   exp_grant);
        check("wr_en",   buf_wr_en_o,   m_writing);
        check("wr_addr", buf_wr_addr_o, m_waddr);
        check("wr_data", buf_wr_data_o, m_wdata);
        check("pending", pending_o,     exp_pend);
        check("ovf",     ovf_o,         m_ovf);
        check("tmo",     tmo_o,         m_tmo);
        check("inv_onehot", $onehot0(adc_grant_o), 1);
        check("inv_excl",   (|adc_grant_o) && buf_wr_en_o, 0);
    endtask

    logic [DW-1:0] wr_log_data[$];
    int            wr_log_cyc[$];

    // One clock: model and DUT see the same edge, outputs checked 1 ns later,
    // returns at the falling edge where the next inputs are driven.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        cyc++;
        compare_all();
        if (buf_wr_en_o) begin
            wr_log_data.push_back(buf_wr_data_o);
            wr_log_cyc.push_back(cyc);
        end
        @(negedge clk);
    endtask

    task automatic quiet_inputs();
        rst_i          = 1'b0;
        arb_en_i       = 1'b1;
        buf_busy_i     = 1'b0;
        adc_valid_i    = '0;
        wr_grant_ack_i = '0;
        err_clr_i      = 1'b0;
    endtask

    task automatic do_reset();
        quiet_inputs();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
    endtask

    // Runs n cycles; when auto is set the currently granted ADC acks at once.
    task automatic run(input int n, input bit auto_ack);
        for (int i = 0; i < n; i++) begin
            wr_grant_ack_i = '0;
            if (auto_ack && m_owner >= 0) wr_grant_ack_i[m_owner] = 1'b1;
            tick();
        end
        wr_grant_ack_i = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        quiet_inputs();
        adc_data_i     = '0;
        adc_buf_addr_i = '0;
        m_owner        = -1;
        do_reset();
        check("rst_grant", adc_grant_o, 0);
        check("rst_wr_en", buf_wr_en_o, 0);
        check("rst_pend",  pending_o,   0);

        // 1: single ADC, best-case latency
        adc_valid_i[2]    = 1'b1;
        adc_data_i[2]     = 32'hA5A5_0002;
        adc_buf_addr_i[2] = 10'h010;
        tick();
        adc_valid_i = '0;
        check("t1_pend", pending_o, 4'b0100);
        tick();
        check("t1_grant", adc_grant_o, 4'b0100);
        wr_grant_ack_i[2] = 1'b1;
        tick();
        wr_grant_ack_i = '0;
        check("t1_wr_en",  buf_wr_en_o,   1);
        check("t1_addr",   buf_wr_addr_o, 10'h010);
        check("t1_data",   buf_wr_data_o, 32'hA5A5_0002);
        check("t1_gr_off", adc_grant_o,   0);
        tick();
        check("t1_wr_off", buf_wr_en_o, 0);
        check("t1_pend0",  pending_o,   0);

        // 2: round robin over a full burst, then a second burst
        do_reset();
        wr_log_data.delete();
        wr_log_cyc.delete();
        for (int i = 0; i < N; i++) begin
            adc_data_i[i]     = 32'hB000_0000 + i;
            adc_buf_addr_i[i] = AW'(16 * i);
        end
        adc_valid_i = '1;
        tick();
        adc_valid_i = '0;
        run(14, 1'b1);
        check("t2_count", wr_log_data.size(), N);
        for (int i = 0; i < N && i < wr_log_data.size(); i++) begin
            check("t2_order", wr_log_data[i], 32'hB000_0000 + i);
            if (i > 0) check("t2_gap", wr_log_cyc[i] - wr_log_cyc[i-1], 3);
        end
        wr_log_data.delete();
        for (int i = 0; i < N; i++) adc_data_i[i] = 32'hB100_0000 + i;
        adc_valid_i = '1;
        tick();
        adc_valid_i = '0;
        run(14, 1'b1);
        check("t2_rep_first", (wr_log_data.size() > 0) ? wr_log_data[0] : 32'hX, 32'hB100_0000);

        // 3: overflow keeps the first sample; clear drops the flag
        do_reset();
        adc_valid_i[1] = 1'b1;
        adc_data_i[1]  = 32'h11;
        tick();
        adc_data_i[1] = 32'h22;
        tick();
        adc_valid_i = '0;
        check("t3_ovf", ovf_o[1], 1);
        wr_grant_ack_i[1] = 1'b1;
        tick();
        wr_grant_ack_i = '0;
        check("t3_data", buf_wr_data_o, 32'h11);
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        check("t3_clr", ovf_o[1], 0);

        // 4: release and capture in the same cycle
        do_reset();
        wr_log_data.delete();
        adc_valid_i[0] = 1'b1;
        adc_data_i[0]  = 32'hC0;
        tick();
        adc_valid_i = '0;
        tick();
        adc_valid_i[0]    = 1'b1;
        adc_data_i[0]     = 32'hC1;
        wr_grant_ack_i[0] = 1'b1;
        tick();
        adc_valid_i    = '0;
        wr_grant_ack_i = '0;
        check("t4_data", buf_wr_data_o, 32'hC0);
        check("t4_pend", pending_o[0],  1);
        check("t4_ovf",  ovf_o[0],      0);
        run(6, 1'b1);
        check("t4_second", (wr_log_data.size() == 2) ? wr_log_data[1] : 32'hX, 32'hC1);

        // 5: ack timeout on ADC3, ADC0 served next
        do_reset();
        adc_valid_i[3] = 1'b1;
        tick();
        adc_valid_i    = '0;
        adc_valid_i[0] = 1'b1;
        tick();
        adc_valid_i = '0;
        check("t5_grant3", adc_grant_o, 4'b1000);
        run(TMO - 1, 1'b0);
        check("t5_still", adc_grant_o, 4'b1000);
        tick();
        check("t5_drop",  adc_grant_o, 0);
        check("t5_tmo",   tmo_o,       4'b1000);
        check("t5_nowr",  buf_wr_en_o, 0);
        check("t5_pend",  pending_o,   4'b1001);
        tick();
        check("t5_next",  adc_grant_o, 4'b0001);
        run(4, 1'b1);

        // 6: busy blocks the grant; reset aborts a grant
        do_reset();
        buf_busy_i     = 1'b1;
        adc_valid_i[0] = 1'b1;
        tick();
        adc_valid_i = '0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t6_blocked", adc_grant_o, 0);
        end
        buf_busy_i = 1'b0;
        tick();
        check("t6_grant", adc_grant_o, 4'b0001);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("t6_rst_grant", adc_grant_o, 0);
        check("t6_rst_pend",  pending_o,   0);
        check("t6_rst_wr",    buf_wr_en_o, 0);

        // Randomized traffic, ack behaviour changes every 200 cycles
        for (int blk = 0; blk < 15; blk++) begin
            int ack_mode;
            ack_mode = $urandom_range(0, 2);
            for (int c = 0; c < 200; c++) begin
                for (int n = 0; n < N; n++) begin
                    adc_valid_i[n]    = ($urandom_range(0, 3) == 0);
                    adc_data_i[n]     = $urandom;
                    adc_buf_addr_i[n] = AW'($urandom);
                end
                wr_grant_ack_i = N'($urandom & $urandom & $urandom);
                if (m_owner >= 0) begin
                    wr_grant_ack_i[m_owner] = (ack_mode == 2) ||
                        (ack_mode == 1 && $urandom_range(0, 1) == 1);
                end
                arb_en_i   = ($urandom_range(0, 9) != 0);
                buf_busy_i = ($urandom_range(0, 7) == 0);
                err_clr_i  = ($urandom_range(0, 31) == 0);
                rst_i      = ($urandom_range(0, 599) == 0);
                tick();
            end
        end
        quiet_inputs();
        run(40, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
